// File: rtl/cracker_host_ctrl.sv
// Host-side controller for the hash cracker: streams hash bytes from the host into the
// cracker, starts the search, and streams back a marker plus readout bytes per match.
`timescale 1ns/1ps
module cracker_host_ctrl #(
  parameter int unsigned HASH_COUNT    = 2,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       cr_my_turn,
  input  logic       cr_match_found,
  input  logic [7:0] cr_password_byte,
  output logic [7:0] cr_new_hash_byte,
  output logic       cr_store_hash_byte,
  output logic       cr_go,
  output logic [7:0] found_count,
  output logic       done
);

  localparam int unsigned TotalBytes = HASH_COUNT * 16;
  localparam int unsigned ReadBytes  = 21;
  localparam logic [11:0] LastByte   = 12'(TotalBytes - 1);
  localparam logic [4:0]  LastRead   = 5'(ReadBytes - 1);
  localparam logic [3:0]  StrobeLast = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0]  StrobeEnd  = 4'(STROBE_CYCLES);

  typedef enum logic [3:0] {
    StLoadWait,
    StLoadSetup,
    StLoadStrobe,
    StLoadGap,
    StGoWait,
    StGoStrobe,
    StSearch,
    StTxWait,
    StReadWait,
    StReadStrobe,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]  strb_cnt_q, strb_cnt_d;
  logic [4:0]  read_cnt_q, read_cnt_d;
  logic        in_readout_q, in_readout_d;  // pending tx byte is readout data, not a marker
  logic        end_q, end_d;                // pending tx byte is the final 0x00 marker
  logic [7:0]  hash_byte_q, hash_byte_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  found_q, found_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLoadWait;
      byte_cnt_q   <= '0;
      strb_cnt_q   <= '0;
      read_cnt_q   <= '0;
      in_readout_q <= 1'b0;
      end_q        <= 1'b0;
      hash_byte_q  <= '0;
      tx_data_q    <= '0;
      found_q      <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      strb_cnt_q   <= strb_cnt_d;
      read_cnt_q   <= read_cnt_d;
      in_readout_q <= in_readout_d;
      end_q        <= end_d;
      hash_byte_q  <= hash_byte_d;
      tx_data_q    <= tx_data_d;
      found_q      <= found_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    byte_cnt_d         = byte_cnt_q;
    strb_cnt_d         = strb_cnt_q;
    read_cnt_d         = read_cnt_q;
    in_readout_d       = in_readout_q;
    end_d              = end_q;
    hash_byte_d        = hash_byte_q;
    tx_data_d          = tx_data_q;
    found_d            = found_q;
    rx_ready           = 1'b0;
    tx_valid           = 1'b0;
    cr_store_hash_byte = 1'b0;
    cr_go              = 1'b0;
    done               = 1'b0;

    unique case (state_q)
      StLoadWait: begin
        // Reset also sits in this state, so keep rx_ready low while it is held.
        rx_ready = cr_my_turn & ~rst;
        if (rx_valid && rx_ready) begin
          hash_byte_d = rx_data;
          state_d     = StLoadSetup;
        end
      end
      StLoadSetup: state_d = StLoadStrobe;
      StLoadStrobe: begin
        cr_store_hash_byte = 1'b1;
        if (strb_cnt_q == StrobeLast) begin
          strb_cnt_d = '0;
          state_d    = StLoadGap;
        end else begin
          strb_cnt_d = strb_cnt_q + 4'd1;
        end
      end
      StLoadGap: begin
        byte_cnt_d = byte_cnt_q + 12'd1;
        state_d    = (byte_cnt_q == LastByte) ? StGoWait : StLoadWait;
      end
      StGoWait: if (cr_my_turn) state_d = StGoStrobe;
      StGoStrobe: begin
        // High for STROBE_CYCLES counts, then one trailing low cycle.
        cr_go = (strb_cnt_q < StrobeEnd);
        if (strb_cnt_q == StrobeEnd) begin
          strb_cnt_d = '0;
          state_d    = StSearch;
        end else begin
          strb_cnt_d = strb_cnt_q + 4'd1;
        end
      end
      StSearch: begin
        if (cr_my_turn) begin
          tx_data_d    = {7'd0, cr_match_found};
          end_d        = ~cr_match_found;
          in_readout_d = 1'b0;
          read_cnt_d   = '0;
          state_d      = StTxWait;
        end
      end
      StTxWait: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (in_readout_q)  state_d = StReadStrobe;
          else if (end_q)    state_d = StDone;
          else               state_d = StReadWait;
        end
      end
      StReadWait: begin
        if (cr_my_turn) begin
          tx_data_d    = cr_password_byte;
          in_readout_d = 1'b1;
          state_d      = StTxWait;
        end
      end
      StReadStrobe: begin
        cr_go = (strb_cnt_q < StrobeEnd);
        if (strb_cnt_q == StrobeEnd) begin
          strb_cnt_d = '0;
          read_cnt_d = read_cnt_q + 5'd1;
          if (read_cnt_q == LastRead) begin
            found_d      = (found_q == 8'hFF) ? found_q : found_q + 8'd1;
            in_readout_d = 1'b0;
            state_d      = StSearch;
          end else begin
            state_d = StReadWait;
          end
        end else begin
          strb_cnt_d = strb_cnt_q + 4'd1;
        end
      end
      StDone: done = 1'b1;
      default: state_d = StLoadWait;
    endcase
  end

  assign cr_new_hash_byte = hash_byte_q;
  assign tx_data          = tx_data_q;
  assign found_count      = found_q;

endmodule

// File: tb/tb_cracker_host_ctrl.sv
// Directed bench for cracker_host_ctrl: a small cracker model, a host feeder/sink, and an
// event-level monitor checking strobes and tx bytes against expectations built from the hashes.
`timescale 1ns/1ps
module tb_cracker_host_ctrl;

  localparam int unsigned HashCount    = 2;
  localparam int unsigned StrobeCycles = 2;
  localparam int          NumBytes     = HashCount * 16;
  localparam int          NumTx        = 45;  // (marker + 21) per match, twice, then 0x00

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       cr_my_turn;
  logic       cr_match_found;
  logic [7:0] cr_password_byte;
  logic [7:0] cr_new_hash_byte;
  logic       cr_store_hash_byte;
  logic       cr_go;
  logic [7:0] found_count;
  logic       done;

  cracker_host_ctrl #(
    .HASH_COUNT   (HashCount),
    .STROBE_CYCLES(StrobeCycles)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .cr_my_turn        (cr_my_turn),
    .cr_match_found    (cr_match_found),
    .cr_password_byte  (cr_password_byte),
    .cr_new_hash_byte  (cr_new_hash_byte),
    .cr_store_hash_byte(cr_store_hash_byte),
    .cr_go             (cr_go),
    .found_count       (found_count),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [127:0] hashes [HashCount];
  logic [159:0] pw     [2];
  logic [7:0]   pw_len [2];

  function automatic logic [7:0] exp_store(input int i);
    logic [127:0] h;
    h = hashes[i / 16];
    return h[8 * (i % 16) +: 8];
  endfunction

  function automatic logic [7:0] readout_byte(input int m, input int r);
    logic [159:0] p;
    p = pw[m];
    if (r < 20) return p[159 - 8 * r -: 8];
    return pw_len[m];
  endfunction

  function automatic logic [7:0] exp_tx(input int k);
    int m;
    int r;
    if (k >= 44) return 8'h00;
    m = k / 22;
    r = k % 22;
    if (r == 0) return 8'h01;
    return readout_byte(m, r - 1);
  endfunction

  // Cracker model: first go starts the search; every later go advances the readout.
  int   m_idx;
  int   rd_idx;
  int   go_seen;
  logic go_prev;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_idx   <= 0;
      rd_idx  <= 0;
      go_seen <= 0;
      go_prev <= 1'b0;
    end else begin
      if (go_prev && !cr_go) begin
        go_seen <= go_seen + 1;
        if (go_seen > 0) begin
          if (rd_idx == 20) begin
            rd_idx <= 0;
            m_idx  <= m_idx + 1;
          end else begin
            rd_idx <= rd_idx + 1;
          end
        end
      end
      go_prev <= cr_go;
    end
  end

  assign cr_match_found   = (m_idx < 2);
  assign cr_password_byte = (m_idx < 2) ? readout_byte(m_idx, rd_idx) : 8'h00;

  // Per-cycle monitor.
  int         st_count;
  int         st_width;
  int         go_count;
  int         go_width;
  logic       prev_store;
  logic       prev_go;
  logic [7:0] held_hash;
  logic       prev_tx_valid;
  logic       prev_tx_taken;
  logic [7:0] prev_tx_data;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        st_count = 0; st_width = 0; go_count = 0; go_width = 0;
        prev_store = 1'b0; prev_go = 1'b0; held_hash = 8'h00;
        prev_tx_valid = 1'b0; prev_tx_taken = 1'b0; prev_tx_data = 8'h00;
      end else begin
        check("store_go_exclusive", 32'(cr_store_hash_byte & cr_go), 32'd0);
        check("rx_ready_needs_turn", 32'(rx_ready & ~cr_my_turn), 32'd0);
        if (tx_valid) check("strobe_during_tx", 32'(cr_store_hash_byte | cr_go), 32'd0);
        if (done)
          check("done_quiet", 32'({rx_ready, tx_valid, cr_store_hash_byte, cr_go}), 32'd0);
        if (cr_store_hash_byte) begin
          if (!prev_store) begin
            st_width = 1;
            if (st_count < NumBytes)
              check("store_byte", 32'(cr_new_hash_byte), 32'(exp_store(st_count)));
            if (st_count == 0)  check("first_store_byte", 32'(cr_new_hash_byte), 32'h5C);
            if (st_count == 16) check("store17_byte", 32'(cr_new_hash_byte), 32'h05);
            st_count++;
            held_hash = cr_new_hash_byte;
          end else begin
            st_width++;
            check("hash_byte_stable", 32'(cr_new_hash_byte), 32'(held_hash));
          end
        end else if (prev_store) begin
          check("store_width", 32'(st_width), 32'(StrobeCycles));
        end
        if (cr_go) begin
          go_width = prev_go ? go_width + 1 : 1;
        end else if (prev_go) begin
          check("go_width", 32'(go_width), 32'(StrobeCycles));
          go_count++;
        end
        if (prev_tx_valid && !prev_tx_taken) begin
          check("tx_valid_held", 32'(tx_valid), 32'd1);
          check("tx_data_held", 32'(tx_data), 32'(prev_tx_data));
        end
        prev_store    = cr_store_hash_byte;
        prev_go       = cr_go;
        prev_tx_valid = tx_valid;
        prev_tx_taken = tx_valid & tx_ready;
        prev_tx_data  = tx_data;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_store"}, 32'(cr_store_hash_byte), 32'd0);
    check({tag, "_go"}, 32'(cr_go), 32'd0);
    check({tag, "_hash_byte"}, 32'(cr_new_hash_byte), 32'd0);
    check({tag, "_found"}, 32'(found_count), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Holds my_turn low for 10 cycles in the gap after a store, with a byte on offer.
  task automatic turn_pause(input logic [7:0] nxt);
    int   stores;
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); #2; seen = cr_store_hash_byte; end
    for (int c = 0; c < 20 && seen; c++) begin @(negedge clk); #2; seen = cr_store_hash_byte; end
    cr_my_turn = 1'b0;
    rx_valid   = 1'b1;
    rx_data    = nxt;
    stores     = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #2;
      stores += 32'(cr_store_hash_byte);
      check("rx_ready_while_busy", 32'(rx_ready), 32'd0);
    end
    check("no_store_while_busy", 32'(stores), 32'd0);
    rx_valid   = 1'b0;
    cr_my_turn = 1'b1;
  endtask

  task automatic feed();
    int   idx;
    logic paused;
    idx    = 0;
    paused = 1'b0;
    for (int c = 0; c < 2000 && idx < NumBytes; c++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = exp_store(idx);
      #2;
      if (rx_ready) begin
        idx++;
        if (idx == 8 && !paused) begin
          paused = 1'b1;
          turn_pause(exp_store(idx));
        end
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("all_bytes_accepted", 32'(idx), 32'(NumBytes));
  endtask

  task automatic sink();
    int         k;
    int         gos;
    logic       stalled;
    logic [7:0] held;
    k       = 0;
    stalled = 1'b0;
    for (int c = 0; c < 5000 && k < NumTx; c++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #2;
      if (tx_valid && k == 5 && !stalled) begin
        stalled  = 1'b1;
        tx_ready = 1'b0;
        held     = tx_data;
        gos      = 0;
        for (int s = 0; s < 50; s++) begin
          @(negedge clk);
          #2;
          gos += 32'(cr_go);
          check("stall_tx_data", 32'(tx_data), 32'(held));
        end
        check("go_during_stall", 32'(gos), 32'd0);
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) begin
        check("tx_byte", 32'(tx_data), 32'(exp_tx(k)));
        case (k)
          0:  check("found_before_first", 32'(found_count), 32'd0);
          19: check("m1_byte_0x31", 32'(tx_data), 32'h31);
          20: check("m1_byte_0x32", 32'(tx_data), 32'h32);
          21: check("m1_len", 32'(tx_data), 32'h02);
          22: check("found_after_first", 32'(found_count), 32'd1);
          43: check("m2_len", 32'(tx_data), 32'h03);
          44: check("end_marker", 32'(tx_data), 32'h00);
          default: ;
        endcase
        k++;
      end
    end
    check("all_tx_bytes", 32'(k), 32'(NumTx));
  endtask

  initial begin
    int   idx;
    int   rises;
    int   go_end;
    int   st_end;
    logic prev;
    logic aborted;

    hashes[0] = 128'h588FEB889288FB953B5F094D47D1565C;
    hashes[1] = 128'h91D533DC611AC2774431E2D0BAF36805;
    pw[0]     = 160'h3132;
    pw_len[0] = 8'h02;
    pw[1]     = 160'h616263;
    pw_len[1] = 8'h03;

    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    tx_ready   = 1'b0;
    cr_my_turn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_reset_rx_ready", 32'(rx_ready), 32'(cr_my_turn));

    // Aborted load: reset lands during the 5th store pulse.
    idx     = 0;
    rises   = 0;
    prev    = 1'b0;
    aborted = 1'b0;
    for (int c = 0; c < 400 && !aborted; c++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = exp_store(idx);
      #2;
      if (cr_store_hash_byte && !prev) rises++;
      prev = cr_store_hash_byte;
      if (rises == 5) aborted = 1'b1;
      else if (rx_ready) idx++;
    end
    check("abort_in_5th_store", 32'(aborted), 32'd1);
    rst      = 1'b1;
    rx_valid = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    check("abort_post_reset_rx_ready", 32'(rx_ready), 32'(cr_my_turn));

    // Full run.
    fork
      feed();
      sink();
    join

    for (int c = 0; c < 100 && !done; c++) begin @(negedge clk); #2; end
    check("done", 32'(done), 32'd1);
    check("found_final", 32'(found_count), 32'd2);
    check("store_pulses", 32'(st_count), 32'(NumBytes));
    check("go_pulses", 32'(go_count), 32'd43);
    st_end = st_count;
    go_end = go_count;
    repeat (20) @(negedge clk);
    #4;
    check("no_store_after_done", 32'(st_count), 32'(st_end));
    check("no_go_after_done", 32'(go_count), 32'(go_end));
    check("done_held", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
